// File: rtl/jw_ring_pkg.sv
// rtl/jw_ring_pkg.sv - shared widths and pointer arithmetic for the jw_ring ring-buffer controller
package jw_ring_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

  // Wide enough for the largest legal pointer: 10 address bits plus the wrap bit
  localparam int PTR_MAX_W = 11;
  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  // Occupancy from two zero-extended pointers; the caller keeps the low AW+1 bits,
  // which gives the difference modulo 2**(AW+1)
  function automatic ptr_wide_t ptr_count(input ptr_wide_t wr, input ptr_wide_t rd);
    return wr - rd;
  endfunction

endpackage

// File: rtl/jw_ring_ptr.sv
// rtl/jw_ring_ptr.sv - wrap-bit ring pointer with synchronous clear and increment
module jw_ring_ptr #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  // Natural binary wrap toggles the top bit every pass through the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/jw_ring_ctrl.sv
// rtl/jw_ring_ctrl.sv - ring-buffer controller for an external dual-port RAM; JW_RING_OVERWRITE_EN selects logger mode
module jw_ring_ctrl
  import jw_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_inc;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count = PW'(ptr_count(ptr_wide_t'(wr_ptr), ptr_wide_t'(rd_ptr)));

`ifdef JW_RING_OVERWRITE_EN
  // A pop against a full buffer stalls the write so port a never hits the slot being read
  assign wr_ready = !(full && rd_req);
`else
  assign wr_ready = !full;
`endif

  // rst_n gating keeps ram_we at its reset value while reset is asserted
  assign wr_acc = wr_valid && wr_ready && rst_n && !clear;
  assign rd_acc = rd_req && !empty && !clear;

`ifdef JW_RING_OVERWRITE_EN
  // Writing into a full buffer drops the oldest sample by dragging rd_ptr along
  assign rd_inc = rd_acc || (wr_acc && full);
`else
  assign rd_inc = rd_acc;
`endif

  assign ram_we     = wr_acc;
  assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_din_a  = wr_data;
  assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_data    = ram_dout_b;

  jw_ring_ptr #(.WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  jw_ring_ptr #(.WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (rd_inc),
    .ptr   (rd_ptr)
  );

  // The RAM registers ram_addr_b on the accepting edge, so data lines up with this flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

endmodule

// File: tb/tb_jw_ring_ctrl.sv
// tb/tb_jw_ring_ctrl.sv - directed self-checking bench for jw_ring_ctrl with a behavioural dual-port RAM
module tb_jw_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ram_we;
  logic [3:0] ram_addr_a;
  logic [3:0] ram_addr_b;
  logic [7:0] ram_din_a;
  logic [7:0] ram_dout_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:15];
  logic [3:0] addr_b_q;

  jw_ring_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ram_we     (ram_we),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_din_a  (ram_din_a),
    .ram_dout_b (ram_dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_a] <= ram_din_a;
    addr_b_q <= ram_addr_b;
  end
  assign ram_dout_b = mem[addr_b_q];

  task automatic chk(input string tag, input logic ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $error("FAIL %s observed=mismatch expected=match", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_req   = 1'b0;
    tick();
    tick();
    chk("rst_count", count === 5'd0);
    chk("rst_empty", empty === 1'b1);
    chk("rst_full", full === 1'b0);
    chk("rst_rd_valid", rd_valid === 1'b0);
    chk("rst_ram_we", ram_we === 1'b0);
    chk("rst_addr_a", ram_addr_a === 4'd0);
    chk("rst_addr_b", ram_addr_b === 4'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      #1;
      chk("fill_we", ram_we === 1'b1);
      chk("fill_addr_a", ram_addr_a === 4'(i));
      chk("fill_din", ram_din_a === 8'(i));
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("fill_count", count === 5'd16);
    chk("fill_full", full === 1'b1);

`ifdef JW_RING_OVERWRITE_EN
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    #1;
    chk("ow_ready", wr_ready === 1'b1);
    chk("ow_we", ram_we === 1'b1);
    tick();
    wr_valid = 1'b0;
    chk("ow_count", count === 5'd16);
    chk("ow_full", full === 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd_req = 1'b1;
      tick();
      chk("ow_pop_valid", rd_valid === 1'b1);
      chk("ow_pop_data", rd_data === ((i < 15) ? 8'(i + 1) : 8'hAA));
    end
    rd_req = 1'b0;
    #1;
    chk("ow_empty", empty === 1'b1);
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h30 + i);
      tick();
    end
    wr_data = 8'hBB;
    rd_req  = 1'b1;
    #1;
    chk("ow_stall_ready", wr_ready === 1'b0);
    chk("ow_stall_we", ram_we === 1'b0);
    tick();
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    chk("ow_stall_valid", rd_valid === 1'b1);
    chk("ow_stall_data", rd_data === 8'h30);
    chk("ow_stall_count", count === 5'd15);
    clear = 1'b1;
    tick();
    clear = 1'b0;
`else
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    #1;
    chk("over_ready", wr_ready === 1'b0);
    chk("over_we", ram_we === 1'b0);
    tick();
    wr_valid = 1'b0;
    chk("over_count", count === 5'd16);

    for (int i = 0; i < 16; i++) begin
      rd_req = 1'b1;
      tick();
      chk("pop_valid", rd_valid === 1'b1);
      chk("pop_data", rd_data === 8'(i));
    end
    rd_req = 1'b0;
    #1;
    chk("pop_empty", empty === 1'b1);
    chk("pop_count", count === 5'd0);
    tick();
    chk("pop_valid_end", rd_valid === 1'b0);

    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h20 + i);
      tick();
    end
    chk("steady_pre_count", count === 5'd5);
    for (int k = 0; k < 40; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h25 + k);
      rd_req   = 1'b1;
      tick();
      chk("steady_valid", rd_valid === 1'b1);
      chk("steady_data", rd_data === 8'(8'h20 + k));
      chk("steady_count", count === 5'd5);
    end
    rd_req  = 1'b0;
    wr_data = 8'h50;
    tick();
    wr_data = 8'h51;
    tick();
    wr_valid = 1'b0;
    chk("clr_pre_count", count === 5'd7);

    clear    = 1'b1;
    rd_req   = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    #1;
    chk("clr_we", ram_we === 1'b0);
    tick();
    clear    = 1'b0;
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    chk("clr_count", count === 5'd0);
    chk("clr_empty", empty === 1'b1);
    chk("clr_rd_valid", rd_valid === 1'b0);
    chk("clr_addr_a", ram_addr_a === 4'd0);
    chk("clr_addr_b", ram_addr_b === 4'd0);

    wr_valid = 1'b1;
    wr_data  = 8'h77;
    tick();
    wr_valid = 1'b0;
    rd_req   = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("post_clr_data", rd_data === 8'h77);
    chk("post_clr_valid", rd_valid === 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
`endif

    rd_req = 1'b1;
    #1;
    chk("empty_rd_addr_b", ram_addr_b === 4'd0);
    tick();
    rd_req = 1'b0;
    chk("empty_rd_valid", rd_valid === 1'b0);
    chk("empty_rd_count", count === 5'd0);
    chk("empty_rd_addr_b2", ram_addr_b === 4'd0);

    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h61 + i);
      tick();
    end
    wr_data = 8'h64;
    rd_req  = 1'b1;
    tick();
    chk("burst_valid", rd_valid === 1'b1);
    chk("burst_data", rd_data === 8'h61);
    chk("burst_count", count === 5'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_count", count === 5'd0);
    chk("async_empty", empty === 1'b1);
    chk("async_full", full === 1'b0);
    chk("async_rd_valid", rd_valid === 1'b0);
    chk("async_we", ram_we === 1'b0);
    chk("async_addr_a", ram_addr_a === 4'd0);
    chk("async_addr_b", ram_addr_b === 4'd0);
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", count === 5'd0);
    chk("post_rst_valid", rd_valid === 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
